// File: rtl/array_pkg.sv
// Shared types, sizes and helpers for the array-to-stream datapath.
package array_pkg;

  localparam int ARR_ROWS  = 16;
  localparam int ARR_COLS  = 9;
  localparam int ARR_WIDTH = 32;

  typedef logic [ARR_WIDTH-1:0] word_t;

  typedef enum logic [0:0] {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_e;

  // Bit offset of word (r,c) inside a flattened frame.
  function automatic int unsigned flat_offset(input int unsigned r, input int unsigned c);
    return (r * ARR_COLS + c) * ARR_WIDTH;
  endfunction

  function automatic logic even_parity(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/array_idx_counter.sv
// Row-major (row, col) position counter with terminal-word flag and clear.
import array_pkg::*;

module array_idx_counter #(
  parameter int ROWS  = ARR_ROWS,
  parameter int COLS  = ARR_COLS,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last
);

  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic             row_end_s;
  logic             col_end_s;

  assign row_end_s = (row_r == ROW_W'(ROWS - 1));
  assign col_end_s = (col_r == COL_W'(COLS - 1));

  // Advance through the frame; the last word wraps back to (0,0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_r <= '0;
      col_r <= '0;
    end else if (i_clear) begin
      row_r <= '0;
      col_r <= '0;
    end else if (i_inc) begin
      if (col_end_s) begin
        col_r <= '0;
        if (row_end_s) begin
          row_r <= '0;
        end else begin
          row_r <= row_r + ROW_W'(1);
        end
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  assign o_row  = row_r;
  assign o_col  = col_r;
  assign o_last = row_end_s & col_end_s;

endmodule

// File: rtl/array_serializer.sv
// Captures a whole ROWS x COLS frame and replays it word-serially in row-major order.
// Optional even-parity output enabled by ARRAY_SERIALIZER_PARITY_EN.
import array_pkg::*;

module array_serializer #(
  parameter int ROWS  = ARR_ROWS,
  parameter int COLS  = ARR_COLS,
  parameter int WIDTH = ARR_WIDTH,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [ROWS*COLS*WIDTH-1:0]  i_frame,
  input  logic                        i_frame_valid,
  output logic                        o_frame_ready,
  output logic [WIDTH-1:0]            o_word,
  output logic                        o_word_valid,
  input  logic                        i_word_ready,
  output logic [ROW_W-1:0]            o_row,
  output logic [COL_W-1:0]            o_col,
  output logic                        o_sof,
  output logic                        o_eol,
  output logic                        o_eof
`ifdef ARRAY_SERIALIZER_PARITY_EN
  ,
  output logic                        o_word_par
`endif
);

  ser_state_e       state_r;
  logic             word_valid_r;
  logic [WIDTH-1:0] frame_buf_r [ROWS][COLS];
  logic [ROW_W-1:0] row_s;
  logic [COL_W-1:0] col_s;
  logic             last_s;
  logic             word_hs_s;
  logic             last_hs_s;
  logic             frame_ready_s;
  logic             frame_hs_s;

  assign word_hs_s     = word_valid_r & i_word_ready;
  assign last_hs_s     = word_hs_s & last_s;
  assign frame_ready_s = (state_r == SER_IDLE) | ((state_r == SER_STREAM) & last_hs_s);
  assign frame_hs_s    = i_frame_valid & frame_ready_s;

  array_idx_counter #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_idx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (frame_hs_s),
    .i_inc   (word_hs_s),
    .o_row   (row_s),
    .o_col   (col_s),
    .o_last  (last_s)
  );

  // Control FSM: a last-word handshake with a waiting frame restarts without a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= SER_IDLE;
      word_valid_r <= 1'b0;
    end else begin
      case (state_r)
        SER_IDLE: begin
          if (frame_hs_s) begin
            state_r      <= SER_STREAM;
            word_valid_r <= 1'b1;
          end
        end
        SER_STREAM: begin
          if (last_hs_s && !i_frame_valid) begin
            state_r      <= SER_IDLE;
            word_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= SER_IDLE;
          word_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Frame buffer, loaded only on a frame handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          frame_buf_r[r][c] <= '0;
        end
      end
    end else if (frame_hs_s) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          frame_buf_r[r][c] <= i_frame[(r*COLS+c)*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign o_frame_ready = frame_ready_s;
  assign o_word        = frame_buf_r[row_s][col_s];
  assign o_word_valid  = word_valid_r;
  assign o_row         = row_s;
  assign o_col         = col_s;
  assign o_sof         = word_valid_r & (row_s == ROW_W'(0)) & (col_s == COL_W'(0));
  assign o_eol         = word_valid_r & (col_s == COL_W'(COLS - 1));
  assign o_eof         = word_valid_r & last_s;

`ifdef ARRAY_SERIALIZER_PARITY_EN
  assign o_word_par = word_valid_r & even_parity(o_word);
`endif

endmodule

// File: tb/tb_array_serializer.sv
// Scoreboard bench for array_serializer: stimulus pushes expected words, a monitor pops and compares.
import array_pkg::*;

module tb_array_serializer;

  localparam int ROWS = ARR_ROWS;
  localparam int COLS = ARR_COLS;
  localparam int FW   = ROWS * COLS * ARR_WIDTH;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [FW-1:0] i_frame;
  logic          i_frame_valid;
  logic          o_frame_ready;
  logic [31:0]   o_word;
  logic          o_word_valid;
  logic          i_word_ready;
  logic [3:0]    o_row;
  logic [3:0]    o_col;
  logic          o_sof;
  logic          o_eol;
  logic          o_eof;
`ifdef ARRAY_SERIALIZER_PARITY_EN
  logic          o_word_par;
`endif

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  logic [FW-1:0] frame_a, frame_c, frame_junk;

  array_serializer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame       (i_frame),
    .i_frame_valid (i_frame_valid),
    .o_frame_ready (o_frame_ready),
    .o_word        (o_word),
    .o_word_valid  (o_word_valid),
    .i_word_ready  (i_word_ready),
    .o_row         (o_row),
    .o_col         (o_col),
    .o_sof         (o_sof),
    .o_eol         (o_eol),
    .o_eof         (o_eof)
`ifdef ARRAY_SERIALIZER_PARITY_EN
    ,
    .o_word_par    (o_word_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the first n words of a frame, in row-major order, onto the scoreboard.
  task automatic push_frame(input logic [FW-1:0] f, input int n);
    int k;
    exp_t e;
    k = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (k < n) begin
          e.word = f[flat_offset(r, c) +: 32];
          e.row  = 4'(r);
          e.col  = 4'(c);
          e.sof  = (r == 0) && (c == 0);
          e.eol  = (c == COLS - 1);
          e.eof  = (r == ROWS - 1) && (c == COLS - 1);
          sb.push_back(e);
        end
        k++;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare each accepted word and verify stability across stalls.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word;
  logic [3:0]  prev_row, prev_col;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(o_word_valid), 64'd1);
        check("stall_word", 64'(o_word), 64'(prev_word));
        check("stall_rowcol", 64'({o_row, o_col}), 64'({prev_row, prev_col}));
      end
      if (o_word_valid && i_word_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 64'(o_word), 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = sb.pop_front();
          check("word", 64'(o_word), 64'(e.word));
          check("row", 64'(o_row), 64'(e.row));
          check("col", 64'(o_col), 64'(e.col));
          check("sof", 64'(o_sof), 64'(e.sof));
          check("eol", 64'(o_eol), 64'(e.eol));
          check("eof", 64'(o_eof), 64'(e.eof));
`ifdef ARRAY_SERIALIZER_PARITY_EN
          check("parity", 64'(o_word_par), 64'(^e.word));
`endif
        end
      end
      prev_stall = o_word_valid && !i_word_ready;
      prev_word  = o_word;
      prev_row   = o_row;
      prev_col   = o_col;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 64'(o_word_valid), 64'd0);
    check({tag, "_fready"}, 64'(o_frame_ready), 64'd1);
    check({tag, "_rowcol"}, 64'({o_row, o_col}), 64'd0);
    check({tag, "_marks"}, 64'({o_sof, o_eol, o_eof}), 64'd0);
    check({tag, "_word"}, 64'(o_word), 64'd0);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        frame_a[flat_offset(r, c) +: 32]    = 32'(r * 256 + c);
        frame_c[flat_offset(r, c) +: 32]    = 32'(r * COLS + c);
        frame_junk[flat_offset(r, c) +: 32] = 32'hBAD0_0000 | 32'(r * 256 + c);
      end
    end

    rst_n = 1'b0;
    i_frame = '0;
    i_frame_valid = 1'b0;
    i_word_ready = 1'b1;
    #12;
    check_reset_values("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single frame, ready held high.
    push_frame(frame_a, ROWS * COLS);
    i_frame = frame_a;
    i_frame_valid = 1'b1;
    @(negedge clk);
    check("idle_fready", 64'(o_frame_ready), 64'd1);
    tick();
    i_frame_valid = 1'b0;
    i_frame = frame_junk;
    @(negedge clk);
    check("latency_valid", 64'(o_word_valid), 64'd1);
    tick();
    wait_drain(400);
    @(negedge clk);
    check("idle_after_frame", 64'(o_word_valid), 64'd0);
    tick();

    // Back-to-back frames; the waiting frame is only captured on the last handshake.
    push_frame(frame_a, ROWS * COLS);
    push_frame(frame_a, ROWS * COLS);
    i_frame = frame_a;
    i_frame_valid = 1'b1;
    tick();
    for (int k = 0; k < ROWS * COLS; k++) begin
      i_frame = (k == ROWS * COLS - 1) ? frame_a : frame_junk;
      @(negedge clk);
      check("b2b_fready", 64'(o_frame_ready), 64'(k == ROWS * COLS - 1));
      check("b2b_valid", 64'(o_word_valid), 64'd1);
      tick();
    end
    i_frame_valid = 1'b0;
    i_frame = frame_junk;
    for (int k = 0; k < ROWS * COLS; k++) begin
      @(negedge clk);
      check("b2b2_valid", 64'(o_word_valid), 64'd1);
      check("b2b2_fready", 64'(o_frame_ready), 64'(k == ROWS * COLS - 1));
      tick();
    end
    @(negedge clk);
    check("b2b_end_valid", 64'(o_word_valid), 64'd0);
    check("b2b_end_fready", 64'(o_frame_ready), 64'd1);
    check("b2b_drained", 64'(sb.size()), 64'd0);
    tick();

    // Random backpressure; input frame bus scribbled mid-stream.
    push_frame(frame_c, ROWS * COLS);
    i_frame = frame_c;
    i_frame_valid = 1'b1;
    tick();
    i_frame_valid = 1'b0;
    i_frame = '1;
    begin
      int cyc;
      cyc = 0;
      while (sb.size() != 0 && cyc < 3000) begin
        i_word_ready = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
    end
    check("rand_drain", 64'(sb.size()), 64'd0);
    i_word_ready = 1'b1;
    tick();
    @(negedge clk);
    check("rand_idle", 64'(o_word_valid), 64'd0);
    tick();

    // Asynchronous reset with word 40 on the output.
    push_frame(frame_a, 40);
    i_frame = frame_a;
    i_frame_valid = 1'b1;
    tick();
    i_frame_valid = 1'b0;
    wait_drain(200);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    push_frame(frame_a, ROWS * COLS);
    i_frame = frame_a;
    i_frame_valid = 1'b1;
    tick();
    i_frame_valid = 1'b0;
    wait_drain(400);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
